// File: rtl/cpu_pkg.sv
// Shared payload layout for the CPU inter-stage registers.
// A beat is PC, instruction and five per-stage result words, PC in the low bits.
package cpu_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_RES   = 5;
    localparam int PC_LSB    = 0;
    localparam int INSTR_LSB = PC_LSB + WORD_W;
    localparam int RES_LSB   = INSTR_LSB + WORD_W;
    localparam int PAYLOAD_W = RES_LSB + NUM_RES * WORD_W;

    // A bubble is an all-zero payload, so a killed stage reads as a NOP.
    localparam logic [WORD_W-1:0] NOP_WORD = '0;

    function automatic logic [PAYLOAD_W-1:0] pack_pc_instr(
        input logic [WORD_W-1:0] pc,
        input logic [WORD_W-1:0] instr
    );
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        p[PC_LSB +: WORD_W]    = pc;
        p[INSTR_LSB +: WORD_W] = instr;
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register between CPU stages, with an optional skid entry
// so that in_ready is a flop output rather than a function of out_ready.
module pipe_stage_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W    = PAYLOAD_W,
    parameter bit SKID      = 1'b1,
    parameter bit ZERO_KILL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    localparam logic [DATA_W-1:0] NOP_PAYLOAD = DATA_W'(NOP_WORD);

    logic              kill;
    logic              accept;
    logic              pop;
    logic              skid_valid;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] main_kill_data;

    assign kill           = flush | req;
    assign accept         = in_valid & in_ready;
    assign pop            = main_valid_q & out_ready;
    assign main_kill_data = ZERO_KILL ? NOP_PAYLOAD : main_data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            // NOTE: the payload flops are reset as well, not just the valid bit,
            // so out_data reads as a NOP straight out of reset.
            main_data_q  <= NOP_PAYLOAD;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    if (SKID) begin : g_skid
        logic              skid_valid_q, skid_valid_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;
        logic [DATA_W-1:0] skid_kill_data;

        assign skid_kill_data = ZERO_KILL ? NOP_PAYLOAD : skid_data_q;

        // The skid entry only fills while main is stalled, so it is always the younger beat.
        always_comb begin
            // NOTE: every output gets a default first so no path leaves it unassigned
            // and no latch is inferred.
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (kill) begin
                main_valid_d = 1'b0;
                main_data_d  = main_kill_data;
                skid_valid_d = 1'b0;
                skid_data_d  = skid_kill_data;
            end else if (!main_valid_q) begin
                if (accept) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end
            end else if (pop) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = skid_kill_data;
                end else if (accept) begin
                    main_data_d  = in_data;
                end else begin
                    main_valid_d = 1'b0;
                    main_data_d  = main_kill_data;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= NOP_PAYLOAD;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end

        assign in_ready   = ~skid_valid_q;
        assign skid_valid = skid_valid_q;
    end else begin : g_single
        assign in_ready   = ~main_valid_q | out_ready;
        assign skid_valid = 1'b0;

        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            if (kill) begin
                main_valid_d = 1'b0;
                main_data_d  = main_kill_data;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else if (pop) begin
                main_valid_d = 1'b0;
                main_data_d  = main_kill_data;
            end
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench: index 0 drives a SKID=1 instance, index 1 a SKID=0 instance.
// Accepted beats are queued by the driver; a negedge monitor checks every pop.
module tb_pipe_stage_buf;
    import cpu_pkg::*;

    localparam int W = PAYLOAD_W;
    typedef logic [W-1:0] data_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    logic  flush     [2];
    logic  req       [2];
    logic  in_valid  [2];
    logic  in_ready  [2];
    logic  out_valid [2];
    logic  out_ready [2];
    data_t in_data   [2];
    data_t out_data  [2];
    logic [1:0] occ  [2];

    int    checks = 0;
    int    errors = 0;
    int    delivered [2] = '{0, 0};
    data_t exp_q0 [$];
    data_t exp_q1 [$];

    pipe_stage_buf #(.DATA_W(W), .SKID(1'b1), .ZERO_KILL(1'b1)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush[0]), .req(req[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .occ(occ[0])
    );

    pipe_stage_buf #(.DATA_W(W), .SKID(1'b0), .ZERO_KILL(1'b1)) u_dut_flat (
        .clk(clk), .reset(reset), .flush(flush[1]), .req(req[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .occ(occ[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input data_t actual, input data_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void sb_push(input int d, input data_t v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endfunction

    function automatic void sb_clear(input int d);
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    data_t exp_v;
                    logic  have;
                    have  = 1'b0;
                    exp_v = '0;
                    if (d == 0 && exp_q0.size() > 0) begin
                        have  = 1'b1;
                        exp_v = exp_q0.pop_front();
                    end else if (d == 1 && exp_q1.size() > 0) begin
                        have  = 1'b1;
                        exp_v = exp_q1.pop_front();
                    end
                    check($sformatf("pop_expected_dut%0d", d), data_t'(have), data_t'(1));
                    if (have) check($sformatf("pop_data_dut%0d", d), out_data[d], exp_v);
                    delivered[d]++;
                end
            end
        end
    end

    // One clock of stimulus, starting and ending at posedge+1.
    task automatic step(input int d, input logic iv, input data_t dat, input logic ordy,
                        input logic fl, input logic rq, output logic acc);
        in_valid[d]  = iv;
        in_data[d]   = dat;
        out_ready[d] = ordy;
        flush[d]     = fl;
        req[d]       = rq;
        @(negedge clk);
        acc = iv & in_ready[d];
        if (acc && !(fl | rq)) sb_push(d, dat);
        @(posedge clk);
        #1;
        if (fl | rq) sb_clear(d);
        in_valid[d] = 1'b0;
        flush[d]    = 1'b0;
        req[d]      = 1'b0;
    endtask

    task automatic drain(input int d);
        logic a;
        int   k;
        k = 0;
        while (out_valid[d] && k < 20) begin
            step(d, 1'b0, '0, 1'b1, 1'b0, 1'b0, a);
            k++;
        end
        check($sformatf("drain_done_dut%0d", d), data_t'(out_valid[d]), '0);
        check($sformatf("drain_sb_empty_dut%0d", d), data_t'(sb_size(d)), '0);
    endtask

    task automatic idle(input int d, input int n);
        logic a;
        for (int i = 0; i < n; i++) step(d, 1'b0, '0, 1'b1, 1'b0, 1'b0, a);
    endtask

    initial begin
        logic  acc;
        int    n;
        int    base;
        data_t x_data;

        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; req[d] = 1'b0; in_valid[d] = 1'b0;
            out_ready[d] = 1'b0; in_data[d] = '0;
        end
        #22 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_out_valid_dut%0d", d), data_t'(out_valid[d]), '0);
            check($sformatf("rst_out_data_dut%0d", d), out_data[d], '0);
            check($sformatf("rst_occ_dut%0d", d), data_t'(occ[d]), '0);
            check($sformatf("rst_in_ready_dut%0d", d), data_t'(in_ready[d]), data_t'(1));
        end

        // Skid fill: 0xA in main, 0xB in skid, then an X beat that must be ignored.
        step(0, 1'b1, data_t'('hA), 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, data_t'('hB), 1'b0, 1'b0, 1'b0, acc);
        check("skid_occ2", data_t'(occ[0]), data_t'(2));
        check("skid_in_ready0", data_t'(in_ready[0]), '0);
        check("skid_head_A", out_data[0], data_t'('hA));
        check("skid_out_valid", data_t'(out_valid[0]), data_t'(1));
        x_data = 'x;
        step(0, 1'b1, x_data, 1'b0, 1'b0, 1'b0, acc);
        check("x_beat_not_accepted", data_t'(acc), '0);
        check("x_beat_occ2", data_t'(occ[0]), data_t'(2));
        check("stall_head_stable", out_data[0], data_t'('hA));
        base = delivered[0];
        drain(0);
        check("skid_two_delivered", data_t'(delivered[0] - base), data_t'(2));

        // Stream 1..8 with out_ready toggling 1,0,1,0 on both variants.
        for (int d = 0; d < 2; d++) begin
            base = delivered[d];
            n = 1;
            for (int c = 0; c < 64 && n <= 8; c++) begin
                step(d, 1'b1, data_t'(n), (c % 2 == 0), 1'b0, 1'b0, acc);
                if (acc) n++;
            end
            check($sformatf("stream_all_accepted_dut%0d", d), data_t'(n), data_t'(9));
            drain(d);
            check($sformatf("stream_delivered_dut%0d", d), data_t'(delivered[d] - base), data_t'(8));
        end

        // Flush with both entries full and 0xC offered.
        step(0, 1'b1, data_t'('h11), 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, data_t'('h22), 1'b0, 1'b0, 1'b0, acc);
        check("flush_pre_occ2", data_t'(occ[0]), data_t'(2));
        base = delivered[0];
        step(0, 1'b1, data_t'('hC), 1'b0, 1'b1, 1'b0, acc);
        check("flush_occ0", data_t'(occ[0]), '0);
        check("flush_out_valid0", data_t'(out_valid[0]), '0);
        check("flush_out_data0", out_data[0], '0);
        idle(0, 4);
        check("flush_no_beat_after", data_t'(delivered[0] - base), '0);

        // Flush with one entry while 0xC is genuinely accepted: it must be dropped.
        step(0, 1'b1, data_t'('h55), 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, data_t'('hC), 1'b0, 1'b1, 1'b0, acc);
        check("flush_accept_happened", data_t'(acc), data_t'(1));
        check("flush1_occ0", data_t'(occ[0]), '0);
        idle(0, 3);
        check("flush1_out_valid0", data_t'(out_valid[0]), '0);

        // SKID=0: flush during a pop plus accept; popped beat counts, 0xC dropped.
        step(1, 1'b1, data_t'('h66), 1'b1, 1'b0, 1'b0, acc);
        check("flat_pre_occ1", data_t'(occ[1]), data_t'(1));
        base = delivered[1];
        step(1, 1'b1, data_t'('hC), 1'b1, 1'b1, 1'b0, acc);
        check("flat_flush_accepted", data_t'(acc), data_t'(1));
        check("flat_flush_occ0", data_t'(occ[1]), '0);
        check("flat_flush_popped", data_t'(delivered[1] - base), data_t'(1));
        idle(1, 3);
        check("flat_flush_out_valid0", data_t'(out_valid[1]), '0);

        // req during a pop with occ=2: head delivered, younger beat killed.
        step(0, 1'b1, data_t'('h33), 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, data_t'('h44), 1'b0, 1'b0, 1'b0, acc);
        base = delivered[0];
        step(0, 1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
        check("req_popped_one", data_t'(delivered[0] - base), data_t'(1));
        check("req_occ0", data_t'(occ[0]), '0);
        check("req_out_valid0", data_t'(out_valid[0]), '0);
        check("req_out_data0", out_data[0], '0);
        idle(0, 3);
        check("req_no_beat_after", data_t'(delivered[0] - base), data_t'(1));

        // SKID=0 full throughput with full-width payloads.
        base = delivered[1];
        for (int i = 0; i < 10; i++) begin
            step(1, 1'b1, pack_pc_instr(32'h1000 + 32'(4 * i), 32'h0000_0013), 1'b1,
                 1'b0, 1'b0, acc);
            check($sformatf("tput_accept_%0d", i), data_t'(acc), data_t'(1));
            check($sformatf("tput_in_ready_%0d", i), data_t'(in_ready[1]), data_t'(1));
            check($sformatf("tput_occ_%0d", i), data_t'(occ[1]), data_t'(1));
        end
        check("tput_delivered_9", data_t'(delivered[1] - base), data_t'(9));
        drain(1);
        check("tput_delivered_10", data_t'(delivered[1] - base), data_t'(10));

        // Asynchronous reset mid-stream with occ=2.
        step(0, 1'b1, data_t'('h77), 1'b0, 1'b0, 1'b0, acc);
        step(0, 1'b1, data_t'('h88), 1'b0, 1'b0, 1'b0, acc);
        check("mid_rst_pre_occ2", data_t'(occ[0]), data_t'(2));
        reset = 1'b1;
        #2;
        check("mid_rst_out_valid", data_t'(out_valid[0]), '0);
        check("mid_rst_out_data", out_data[0], '0);
        check("mid_rst_occ", data_t'(occ[0]), '0);
        check("mid_rst_in_ready", data_t'(in_ready[0]), data_t'(1));
        sb_clear(0);
        sb_clear(1);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        base = delivered[0];
        step(0, 1'b1, data_t'('h99), 1'b1, 1'b0, 1'b0, acc);
        drain(0);
        check("post_rst_delivered", data_t'(delivered[0] - base), data_t'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
